// File: rtl/pulse_interval_logger.sv
// Measures clock-cycle intervals between consecutive single-cycle pulses and
// queues {sat, interval} records in a first-word-fall-through FIFO.
module pulse_interval_logger #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pulse_in,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_interval,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         event_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [AW:0]      LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW-1:0]    PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ZERO  = {AW{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  gap_cnt_r;
  logic [CNT_W-1:0]  gap_inc_s;
  logic              rec_pulse_s;
  logic              rec_sat_s;
  logic [CNT_W-1:0]  event_cnt_r;
  logic              overflow_r;
  logic [CNT_W:0]    mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       level_r;
  logic              full_s, pop_s, push_ok_s, drop_s;
  logic [CNT_W:0]    head_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; a record is produced only by pulses seen while armed
  always_comb begin
    state_s     = state_r;
    rec_pulse_s = 1'b0;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pulse_in) state_s = ST_ARMED;
          else          state_s = ST_IDLE;
        end
        ST_ARMED: begin
          state_s     = ST_ARMED;
          rec_pulse_s = pulse_in;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Saturating gap+1 doubles as the recorded interval min(gap+1, max)
  always_comb begin
    gap_inc_s = (gap_cnt_r == CNT_MAX) ? CNT_MAX : gap_cnt_r + CNT_ONE;
    rec_sat_s = (gap_cnt_r >= (CNT_MAX - CNT_ONE));
  end

  // Gap counter: runs only while armed, restarts on every pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_r <= CNT_ZERO;
    end else if (clear) begin
      gap_cnt_r <= CNT_ZERO;
    end else if (state_r == ST_ARMED) begin
      gap_cnt_r <= pulse_in ? CNT_ZERO : gap_inc_s;
    end else begin
      gap_cnt_r <= CNT_ZERO;
    end
  end

  // Saturating total pulse counter, arming pulse included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt_r <= CNT_ZERO;
    end else if (clear) begin
      event_cnt_r <= CNT_ZERO;
    end else if (pulse_in && (event_cnt_r != CNT_MAX)) begin
      event_cnt_r <= event_cnt_r + CNT_ONE;
    end else begin
      event_cnt_r <= event_cnt_r;
    end
  end

  // When full, a push is accepted only if the head leaves on the same edge
  always_comb begin
    full_s    = (level_r == LVL_FULL);
    pop_s     = (level_r != LVL_ZERO) && out_ready && !clear;
    push_ok_s = rec_pulse_s && (!full_s || pop_s);
    drop_s    = rec_pulse_s && full_s && !pop_s;
    head_s    = mem_r[rd_ptr_r];
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {(CNT_W+1){1'b0}};
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {(CNT_W+1){1'b0}};
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {rec_sat_s, gap_inc_s};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky drop indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign out_valid    = (level_r != LVL_ZERO);
  assign out_interval = out_valid ? head_s[CNT_W-1:0] : CNT_ZERO;
  assign out_sat      = out_valid ? head_s[CNT_W] : 1'b0;
  assign fifo_level   = level_r;
  assign event_count  = event_cnt_r;
  assign overflow     = overflow_r;

endmodule
